// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: operation encodings and
// the number of requesters that contend for the single ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_SUB = 4'd1,
    ALU_ADD = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_EQ  = 4'd8,
    ALU_SLT = 4'd9
  } alu_op_e;

  localparam int NUM_REQ = 2;

endpackage : alu_pkg

// File: rtl/alu_share_arbiter_rsp_slot.sv
// One-entry result register with valid/ready output handshake.
// A load in the same cycle as a drain replaces the old result, so a
// requester can complete one operation per cycle. free_o tells the
// arbiter the slot can take a new result this cycle.
module alu_rsp_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] result_i,
  input  logic                  rsp_ready_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  free_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign free_o      = ~valid_q | rsp_ready_i;
  assign rsp_valid_o = valid_q;
  assign rsp_data_o  = data_q;

  // Next-state: load wins over drain; draining keeps the stale data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = result_i;
    end else if (valid_q && rsp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule : alu_rsp_slot

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// A request is accepted only when its result slot is empty or draining,
// the ALU result is captured on the accepting edge, and per-requester
// saturating grant counters are kept for observability.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_srca,
  input  logic [DATA_WIDTH-1:0]    req0_srcb,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_srca,
  input  logic [DATA_WIDTH-1:0]    req1_srcb,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic [DATA_WIDTH-1:0]    rsp0_data,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp1_data,
  output logic [CNT_WIDTH-1:0]     grant_cnt0,
  output logic [CNT_WIDTH-1:0]     grant_cnt1
);

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] slot_free;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic               rr_q, rr_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REQ];

  assign req_valid = {req1_valid, req0_valid};
  // Reset gates eligibility so no ready is raised during a reset cycle.
  assign elig      = req_valid & slot_free & {NUM_REQ{~reset}};

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign grant_cnt0 = cnt_q[0];
  assign grant_cnt1 = cnt_q[1];

  // Grant: a lone eligible requester wins, a tie goes to the rr pointer.
  always_comb begin
    grant = '0;
    if (&elig) begin
      grant[rr_q] = 1'b1;
    end else begin
      grant = elig;
    end
  end

  // ALU operand/op mux from the granted requester, zero when idle.
  always_comb begin
    alu_srca = '0;
    alu_srcb = '0;
    alu_op   = '0;
    if (grant[0]) begin
      alu_srca = req0_srca;
      alu_srcb = req0_srcb;
      alu_op   = req0_op;
    end else if (grant[1]) begin
      alu_srca = req1_srca;
      alu_srcb = req1_srcb;
      alu_op   = req1_op;
    end
  end

  // Pointer moves to the loser after a grant; counters saturate.
  always_comb begin
    rr_d = rr_q;
    if (grant[0]) begin
      rr_d = 1'b1;
    end else if (grant[1]) begin
      rr_d = 1'b0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  alu_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
    .clk        (clk),
    .reset      (reset),
    .load_i     (grant[0]),
    .result_i   (alu_result),
    .rsp_ready_i(rsp0_ready),
    .rsp_valid_o(rsp0_valid),
    .rsp_data_o (rsp0_data),
    .free_o     (slot_free[0])
  );

  alu_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
    .clk        (clk),
    .reset      (reset),
    .load_i     (grant[1]),
    .result_i   (alu_result),
    .rsp_ready_i(rsp1_ready),
    .rsp_valid_o(rsp1_valid),
    .rsp_data_o (rsp1_data),
    .free_o     (slot_free[1])
  );

endmodule : alu_share_arbiter

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    v;
  logic [1:0]    rr;
  logic [DW-1:0] sa [2];
  logic [DW-1:0] sb [2];
  logic [OW-1:0] op [2];

  logic          rdy0, rdy1, rv0, rv1;
  logic [DW-1:0] a_sa, a_sb, a_res, rd0, rd1;
  logic [OW-1:0] a_op;
  logic [15:0]   gc0, gc1;

  logic          s_rdy0, s_rdy1, s_rv0, s_rv1;
  logic [DW-1:0] s_sa, s_sb, s_res, s_rd0, s_rd1;
  logic [OW-1:0] s_op;
  logic [3:0]    s_gc0, s_gc1;

  int n_chk = 0;
  int n_pass = 0;

  // Behavioural ALU standing in for the real instance.
  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [OW-1:0] o);
    case (o)
      4'd0: return a & b;
      4'd1: return a - b;
      4'd2: return a + b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return DW'($signed(a) >>> b[4:0]);
      4'd8: return {31'b0, a == b};
      4'd9: return {31'b0, $signed(a) < $signed(b)};
      default: return '0;
    endcase
  endfunction

  assign a_res = alu_f(a_sa, a_sb, a_op);
  assign s_res = alu_f(s_sa, s_sb, s_op);

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .reset(rst),
    .req0_valid(v[0]), .req0_ready(rdy0), .req0_srca(sa[0]), .req0_srcb(sb[0]), .req0_op(op[0]),
    .req1_valid(v[1]), .req1_ready(rdy1), .req1_srca(sa[1]), .req1_srcb(sb[1]), .req1_op(op[1]),
    .alu_srca(a_sa), .alu_srcb(a_sb), .alu_op(a_op), .alu_result(a_res),
    .rsp0_valid(rv0), .rsp0_ready(rr[0]), .rsp0_data(rd0),
    .rsp1_valid(rv1), .rsp1_ready(rr[1]), .rsp1_data(rd1),
    .grant_cnt0(gc0), .grant_cnt1(gc1)
  );

  alu_share_arbiter #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(rst),
    .req0_valid(v[0]), .req0_ready(s_rdy0), .req0_srca(sa[0]), .req0_srcb(sb[0]), .req0_op(op[0]),
    .req1_valid(v[1]), .req1_ready(s_rdy1), .req1_srca(sa[1]), .req1_srcb(sb[1]), .req1_op(op[1]),
    .alu_srca(s_sa), .alu_srcb(s_sb), .alu_op(s_op), .alu_result(s_res),
    .rsp0_valid(s_rv0), .rsp0_ready(rr[0]), .rsp0_data(s_rd0),
    .rsp1_valid(s_rv1), .rsp1_ready(rr[1]), .rsp1_data(s_rd1),
    .grant_cnt0(s_gc0), .grant_cnt1(s_gc1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: slot contents, who won last, and unbounded grant totals.
  bit            m_known = 0;
  bit            m_full [2];
  logic [DW-1:0] m_data [2];
  int            m_last = 1;
  int            m_cnt [2];
  bit            last_acc [2];

  function automatic int sat(input int x, input int lim);
    return (x > lim) ? lim : x;
  endfunction

  // One clock: check everything at the negedge, then advance the model
  // across the following posedge.
  task automatic step();
    bit e[2];
    bit g[2];
    logic [DW-1:0] xa, xb, res;
    logic [OW-1:0] xo;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      e[i] = !rst && v[i] && (!m_known || !m_full[i] || rr[i]);
    if (e[0] && e[1]) begin
      g[0] = (m_last == 1);
      g[1] = (m_last == 0);
    end else begin
      g[0] = e[0];
      g[1] = e[1];
    end
    xa = '0; xb = '0; xo = '0;
    for (int i = 0; i < 2; i++)
      if (g[i]) begin xa = sa[i]; xb = sb[i]; xo = op[i]; end
    check("req0_ready", rdy0, g[0]);
    check("req1_ready", rdy1, g[1]);
    check("alu_srca", a_sa, xa);
    check("alu_srcb", a_sb, xb);
    check("alu_op", a_op, xo);
    if (m_known) begin
      check("rsp0_valid", rv0, m_full[0]);
      check("rsp1_valid", rv1, m_full[1]);
      check("rsp0_data", rd0, m_data[0]);
      check("rsp1_data", rd1, m_data[1]);
      check("grant_cnt0", gc0, sat(m_cnt[0], 65535));
      check("grant_cnt1", gc1, sat(m_cnt[1], 65535));
      check("sat_cnt0", s_gc0, sat(m_cnt[0], 15));
      check("sat_cnt1", s_gc1, sat(m_cnt[1], 15));
    end
    res = alu_f(xa, xb, xo);
    @(posedge clk);
    if (rst) begin
      m_known = 1;
      m_last  = 1;
      for (int i = 0; i < 2; i++) begin
        m_full[i] = 0; m_data[i] = '0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (g[i]) begin
          m_full[i] = 1; m_data[i] = res; m_cnt[i]++;
          m_last = i;
        end else if (m_full[i] && rr[i]) begin
          m_full[i] = 0;
        end
      end
    end
    for (int i = 0; i < 2; i++) last_acc[i] = g[i];
    #1;
  endtask

  task automatic set_req(input int i, input bit val, input logic [OW-1:0] o,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    v[i] = val; op[i] = o; sa[i] = a; sb[i] = b;
  endtask

  initial begin
    rst = 1'b1; v = '0; rr = '0;
    for (int i = 0; i < 2; i++) set_req(i, 0, '0, '0, '0);

    // Reset held two cycles with a pending request.
    set_req(0, 1, ALU_ADD, 32'd5, 32'd7);
    rr = 2'b11;
    step();
    step();
    check("reset_rsp0_valid", rv0, 1'b0);
    check("reset_cnt0", gc0, 16'd0);

    // Single ADD from requester 0.
    rst = 1'b0;
    step();
    check("add_rsp0_valid", rv0, 1'b1);
    check("add_rsp0_data", rd0, 32'd12);
    check("add_cnt0", gc0, 16'd1);
    v[0] = 0;
    step();

    // Contention: both valid for 8 cycles from a clean reset.
    rst = 1'b1; step(); rst = 1'b0;
    set_req(0, 1, ALU_SUB, 32'd10, 32'd3);
    set_req(1, 1, ALU_XOR, 32'hF0, 32'h0F);
    for (int c = 0; c < 8; c++) step();
    check("cont_cnt0", gc0, 16'd4);
    check("cont_cnt1", gc1, 16'd4);
    check("cont_rsp0_data", rd0, 32'd7);
    check("cont_rsp1_data", rd1, 32'hFF);

    // Back-pressure on requester 1 while requester 0 streams.
    rr = 2'b01;
    for (int c = 0; c < 4; c++) step();
    check("bp_rsp1_data", rd1, 32'hFF);
    check("bp_rsp1_valid", rv1, 1'b1);
    rr = 2'b11;
    step();
    check("bp_release_grant1", last_acc[1], 1'b1);

    // Full throughput on requester 0 with SLT pairs.
    v[1] = 0;
    step();
    set_req(0, 1, ALU_SLT, 32'd1, 32'd2);
    step();
    check("slt_a_data", rd0, 32'd1);
    set_req(0, 1, ALU_SLT, 32'd3, 32'd2);
    step();
    check("slt_b_data", rd0, 32'd0);
    check("slt_b_valid", rv0, 1'b1);

    // Saturation of the 4-bit counter instance.
    rst = 1'b1; step(); rst = 1'b0;
    set_req(0, 1, ALU_OR, 32'h1, 32'h2);
    for (int c = 0; c < 20; c++) step();
    check("sat_stop", s_gc0, 4'd15);
    check("nosat_cnt", gc0, 16'd20);

    // Random traffic honouring the hold-until-ready rule.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!(v[i] && !last_acc[i])) begin
          set_req(i, ($urandom_range(0, 3) != 0), OW'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) != 0) ? DW'($urandom) : DW'($urandom_range(0, 40)),
                  ($urandom_range(0, 1) != 0) ? DW'($urandom) : DW'($urandom_range(0, 40)));
        end
        rr[i] = ($urandom_range(0, 9) < 7);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_alu_share_arbiter

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares a single combinational ALU between two requesters, for example the integer issue port and the address/branch-compare port.
- Arbitrates round-robin and drives the ALU operand and operation inputs.
- Captures the ALU result into a per-requester one-entry response register with valid/ready handshakes on both sides.
- Sits between the issue logic and the ALU instance; the ALU itself stays unchanged.

Parameters:
- DATA_WIDTH, 32, width of operands and result.
- OPCODE_LENGTH, 4, width of the ALU operation code.
- CNT_WIDTH, 16, width of each per-requester saturating grant counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_srca  in  DATA_WIDTH  requester 0 operand A.
- req0_srcb  in  DATA_WIDTH  requester 0 operand B.
- req0_op  in  OPCODE_LENGTH  requester 0 operation code.
- req1_valid, req1_ready, req1_srca, req1_srcb, req1_op: same as requester 0, for requester 1.
- alu_srca  out  DATA_WIDTH  to ALU SrcA.
- alu_srcb  out  DATA_WIDTH  to ALU SrcB.
- alu_op  out  OPCODE_LENGTH  to ALU Operation.
- alu_result  in  DATA_WIDTH  from ALU ALUResult (combinational).
- rsp0_valid  out  1  result for requester 0 held.
- rsp0_ready  in  1  requester 0 consumes its result.
- rsp0_data  out  DATA_WIDTH  requester 0 result.
- rsp1_valid, rsp1_ready, rsp1_data: same as requester 0, for requester 1.
- grant_cnt0  out  CNT_WIDTH  saturating count of grants to requester 0.
- grant_cnt1  out  CNT_WIDTH  saturating count of grants to requester 1.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on reset; it takes priority over every other update.
- Reset values:
  - rsp0_valid = rsp1_valid = 0.
  - rsp0_data = rsp1_data = 0.
  - Round-robin pointer rr = 0 (requester 0 preferred first).
  - grant_cnt0 = grant_cnt1 = 0.
- Reset mid-operation: pending responses are discarded; no ready is asserted during the reset cycle.
- Eligibility (combinational): requester i is eligible when reqi_valid = 1 AND (rspi_valid = 0 OR rspi_ready = 1).
- Grant:
  - Exactly one requester eligible: it is granted.
  - Both eligible: requester rr is granted.
  - Neither eligible: no grant.
  - At most one grant per cycle.
- reqi_ready = granti. This is a combinational function of the eligibility inputs and rr, with no dependency on alu_result.
- ALU drive:
  - On a grant, alu_srca, alu_srcb and alu_op are muxed from the granted requester.
  - With no grant, they are driven to all-zero.
- Capture: on the rising edge ending a cycle in which requester i is granted:
  - rspi_data <= alu_result;
  - rspi_valid <= 1.
- Drain: if rspi_valid = 1, rspi_ready = 1 and requester i is not granted, then rspi_valid <= 0 and rspi_data holds its value.
- Simultaneous drain and grant on the same requester: the new result replaces the old one, rspi_valid stays 1, giving full throughput of one operation per cycle per requester.
- Latency: accept in cycle N, result valid at cycle N+1.
- Back-pressure: while rspi_valid = 1 and rspi_ready = 0, reqi_ready = 0. The response register holds data and valid stable until consumed.
- Requester rules:
  - Requesters hold valid, operands and op stable until ready.
  - The block does not latch request operands.
- Round-robin: after any grant, rr <= index of the requester not granted. rr is unchanged with no grant. Neither requester can wait more than one cycle while eligible.
- Counters: grant_cnti increments on each granti and saturates at 2^CNT_WIDTH-1, with no wrap.
- Opcode values are passed through unchecked. Undefined codes reach the ALU as-is.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [3:0] alu_op_e: ALU_AND=0, ALU_SUB=1, ALU_ADD=2, ALU_OR=3, ALU_XOR=4, ALU_SLL=5, ALU_SRL=6, ALU_SRA=7, ALU_EQ=8, ALU_SLT=9.
  - Localparam NUM_REQ=2.
- Sub-module alu_rsp_slot: one-entry valid/ready result register with load, drain and simultaneous load+drain behaviour. It also exports a "free" output (empty or draining) used in eligibility. Instantiated twice.

Test Plan:
- Reset sequence: assert reset for 2 cycles with req0_valid=1 -> req0_ready=0, rsp*_valid=0, grant_cnt*=0 throughout; after release, requester 0 granted first.
- Single request: req0 op=ALU_ADD(2), srca=5, srcb=7, rsp0_ready=1 -> req0_ready=1 in cycle N; alu_op=2 in cycle N; rsp0_valid=1 and rsp0_data=12 in cycle N+1; grant_cnt0=1.
- Contention: both valid every cycle, req0 ALU_SUB 10-3, req1 ALU_XOR 0xF0^0x0F, both rsp_ready=1 -> grants alternate 0,1,0,1; rsp0_data=7, rsp1_data=0xFF; counters equal after 8 cycles (4 each).
- Back-pressure: rsp1_ready=0 with rsp1 holding 0xFF, req1 valid -> req1_ready=0 and rsp1_data stays 0xFF; req0 granted every cycle; raise rsp1_ready -> req1 granted in that same cycle.
- Full throughput: req0 continuous ALU_SLT pairs (1,2),(3,2), rsp0_ready=1, req1 idle -> one grant per cycle; rsp0_data sequence 1,0 with rsp0_valid held high.
- Saturation (CNT_WIDTH=4 override): 20 grants to req0 -> grant_cnt0 stops at 15.
